// File: rtl/dds_spi_sequencer_pkg.sv
// rtl/dds_spi_sequencer_pkg.sv - shared states, instruction-byte layout and timing defaults
package dds_spi_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_IOUP  = 3'd5,
        ST_RESP  = 3'd6
    } seq_state_t;

    localparam int INSTR_RW_BIT   = 7;
    localparam int INSTR_ADDR_W   = 5;

    localparam int DEF_MAX_BYTES  = 8;
    localparam int DEF_CS_SETUP   = 2;
    localparam int DEF_CS_HOLD    = 2;
    localparam int DEF_IOUP_WIDTH = 4;
    localparam int DEF_TIMEOUT    = 4095;

    function automatic logic [7:0] make_instr(input logic rd, input logic [INSTR_ADDR_W-1:0] addr);
        logic [7:0] b;
        b = '0;
        b[INSTR_RW_BIT] = rd;
        b[INSTR_ADDR_W-1:0] = addr;
        return b;
    endfunction

    function automatic int unsigned max_int(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The timer flags zero on the last cycle of a window, so an N-cycle window loads N-1.
    function automatic int unsigned cycles_to_load(input int unsigned n);
        return (n > 0) ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/dds_spi_sequencer_pulse_timer.sv
// rtl/dds_spi_sequencer_pulse_timer.sv - loadable down-counter with zero flag (dds_pulse_timer)
module dds_pulse_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dds_spi_sequencer.sv
// rtl/dds_spi_sequencer.sv - DDS register transaction sequencer over a single-byte SPI engine
module dds_spi_sequencer
    import dds_spi_sequencer_pkg::*;
#(
    parameter int MAX_BYTES  = DEF_MAX_BYTES,
    parameter int CS_SETUP   = DEF_CS_SETUP,
    parameter int CS_HOLD    = DEF_CS_HOLD,
    parameter int IOUP_WIDTH = DEF_IOUP_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_read,
    input  logic [4:0]             req_addr,
    input  logic [3:0]             req_len,
    input  logic [8*MAX_BYTES-1:0] req_data,
    input  logic                   req_ioup,
    output logic                   resp_valid,
    output logic [8*MAX_BYTES-1:0] resp_data,
    output logic                   resp_err,
    output logic [7:0]             spi_din,
    output logic                   spi_start,
    input  logic                   spi_done,
    input  logic [7:0]             spi_dout,
    output logic                   CSB,
    output logic                   IO_UPDATE
);

    localparam int DW   = 8 * MAX_BYTES;
    localparam int LW   = $clog2(MAX_BYTES + 1);
    localparam int RW   = $clog2(MAX_BYTES + 2);
    localparam int TMAX = max_int(max_int(CS_SETUP, CS_HOLD), max_int(IOUP_WIDTH, TIMEOUT));
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] LD_SETUP   = TW'(cycles_to_load(CS_SETUP));
    localparam logic [TW-1:0] LD_HOLD    = TW'(cycles_to_load(CS_HOLD));
    localparam logic [TW-1:0] LD_IOUP    = TW'(cycles_to_load(IOUP_WIDTH));
    localparam logic [TW-1:0] LD_TIMEOUT = TW'(cycles_to_load(TIMEOUT));

    seq_state_t state, state_nxt;

    logic          rd_q, ioup_q, err_q;
    logic [7:0]    instr_q;
    logic [DW-1:0] tx_q, rx_q;
    logic [RW-1:0] rem_q;
    logic          sent_instr_q, cur_data_q;
    logic [7:0]    spi_din_q;

    logic          tmr_load, tmr_zero;
    logic [TW-1:0] tmr_val;

    logic [LW-1:0] len_c;
    logic [31:0]   pad_bytes;
    logic [DW-1:0] tx_init;
    logic          accept, byte_done, last_byte, load_byte, timed_out;

    dds_pulse_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Payload is left-justified on accept so data bytes always leave from the top.
    always_comb begin
        len_c = LW'(MAX_BYTES);
        if ({28'd0, req_len} <= 32'(MAX_BYTES)) begin
            len_c = LW'(req_len);
        end
        pad_bytes = 32'(MAX_BYTES) - 32'(len_c);
        tx_init   = req_data << {pad_bytes[28:0], 3'b000};
    end

    assign accept    = (state == ST_IDLE) && req_valid;
    assign byte_done = (state == ST_WAIT) && spi_done;
    assign timed_out = (state == ST_WAIT) && !spi_done && tmr_zero;
    assign last_byte = (rem_q == RW'(1));
    assign load_byte = (state_nxt == ST_START) && (state != ST_START);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT;
                tmr_load  = 1'b1;
                tmr_val   = LD_TIMEOUT;
            end
            ST_WAIT: begin
                if (spi_done && !last_byte) begin
                    state_nxt = ST_START;
                end else if (spi_done || tmr_zero) begin
                    state_nxt = ST_HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    if (!rd_q && ioup_q && !err_q) begin
                        state_nxt = ST_IOUP;
                        tmr_load  = 1'b1;
                        tmr_val   = LD_IOUP;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_IOUP: begin
                if (tmr_zero) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        CSB        = !((state == ST_SETUP) || (state == ST_START) ||
                       (state == ST_WAIT)  || (state == ST_HOLD));
        spi_start  = (state == ST_START);
        IO_UPDATE  = (state == ST_IOUP);
        resp_valid = (state == ST_RESP);
        resp_err   = (state == ST_RESP) && err_q;
        resp_data  = ((state == ST_RESP) && rd_q) ? rx_q : '0;
    end

    assign spi_din = spi_din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q         <= 1'b0;
            ioup_q       <= 1'b0;
            err_q        <= 1'b0;
            instr_q      <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            rem_q        <= '0;
            sent_instr_q <= 1'b0;
            cur_data_q   <= 1'b0;
            spi_din_q    <= '0;
        end else begin
            if (accept) begin
                rd_q         <= req_read;
                ioup_q       <= req_ioup;
                err_q        <= 1'b0;
                instr_q      <= make_instr(req_read, req_addr);
                tx_q         <= tx_init;
                rx_q         <= '0;
                rem_q        <= RW'(len_c) + RW'(1);
                sent_instr_q <= 1'b0;
                cur_data_q   <= 1'b0;
            end
            // The instruction byte always goes first; data bytes follow from the payload top.
            if (load_byte) begin
                spi_din_q  <= sent_instr_q ? tx_q[DW-1 -: 8] : instr_q;
                cur_data_q <= sent_instr_q;
                if (sent_instr_q) begin
                    tx_q <= tx_q << 8;
                end else begin
                    sent_instr_q <= 1'b1;
                end
            end
            if (byte_done) begin
                rem_q <= rem_q - RW'(1);
                if (rd_q && cur_data_q) begin
                    rx_q <= (rx_q << 8) | DW'(spi_dout);
                end
            end
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dds_spi_sequencer.md
Name: dds_spi_sequencer

Overview:
Sequences complete DDS register transactions (instruction byte plus 0..MAX_BYTES data bytes) over the existing single-byte SPI engine. It accepts one write or read request at a time and drives CSB around the transfer. It issues byte-engine start pulses and collects read-back bytes. After writes it can generate the IO_UPDATE pulse that commits DDS registers. It sits between the host command decoder and the SPI byte engine.

Parameters:
MAX_BYTES, 8, maximum data bytes per transaction (payload width 8*MAX_BYTES)
CS_SETUP, 2, clk cycles CSB low before first start pulse
CS_HOLD, 2, clk cycles after last byte done before CSB high
IOUP_WIDTH, 4, clk cycles IO_UPDATE held high
TIMEOUT, 4095, max clk cycles waiting for byte-engine done before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer idle, request accepted when valid&ready
req_read  in  1  1 = register read, 0 = write
req_addr  in  5  DDS register address
req_len  in  4  data byte count, 0..MAX_BYTES
req_data  in  8*MAX_BYTES  write payload; first byte sent = req_data[8*len-1 -: 8]
req_ioup  in  1  pulse IO_UPDATE after a successful write
resp_valid  out  1  one-cycle pulse at transaction end
resp_data  out  8*MAX_BYTES  read bytes, right-justified, first received byte most significant
resp_err  out  1  valid with resp_valid; 1 = timeout abort
spi_din  out  8  byte to byte engine
spi_start  out  1  one-cycle start pulse to byte engine
spi_done  in  1  byte engine done (high when idle)
spi_dout  in  8  byte received by byte engine
CSB  out  1  DDS chip select, active low
IO_UPDATE  out  1  DDS register commit strobe

Behaviour:
- Interface decided: one clock clk; rst synchronous, active-high.
- Reset (any state, mid-transfer included) → IDLE. Outputs after reset: req_ready=1, CSB=1, IO_UPDATE=0, spi_start=0, spi_din=0, resp_valid=0, resp_err=0, resp_data=0. An in-flight byte in the engine is abandoned.
- States: IDLE, SETUP, START, WAIT, HOLD, IOUP, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields, clamp len>MAX_BYTES to MAX_BYTES, and clear the rx shift register. Go to SETUP with CSB=0.
- Instruction byte is {req_read, 2'b00, req_addr}. It is always the first byte sent. Byte count = len+1. The remaining counter is width clog2(MAX_BYTES+2).
- SETUP: count CS_SETUP cycles, then go to START.
- START: spi_din = current byte, spi_start=1 for exactly one cycle, then go to WAIT. The byte engine clears done asynchronously on start, so the done level sampled in WAIT belongs to the new byte.
- WAIT: spi_done=1 ends the byte.
  - For data bytes of a read, shift spi_dout into rx. The instruction byte's rx is discarded.
  - Decrement remaining. If bytes remain, go to START (back-to-back; CSB stays low). Otherwise go to HOLD.
  - Watchdog: a counter reset on entry to WAIT. Reaching TIMEOUT sets err and goes to HOLD.
- HOLD: CS_HOLD cycles, then CSB=1. If write & req_ioup & !err, go to IOUP; else go to RESP.
- IOUP: IO_UPDATE=1 for IOUP_WIDTH cycles, then go to RESP.
- RESP: resp_valid=1 for one cycle. resp_data = rx for reads, 0 for writes. resp_err = err. Next state is IDLE, with req_ready high the following cycle.
- len=0: instruction byte only. A read with len=0 returns resp_data=0.
- spi_din holds its value between start pulses.
- req_valid outside IDLE is ignored (req_ready=0).
- Latency, write of n bytes with no IOUP: 1 + CS_SETUP + (n+1)·(1+T_byte) + CS_HOLD + 1 cycles, where T_byte is the engine byte time.

Decomposition:
- Shared package/include (config.v): state encodings, instruction-byte field positions (RW bit 7, address [4:0]), and defaults for CS_SETUP, CS_HOLD, IOUP_WIDTH, TIMEOUT.
- One sub-module is natural: dds_pulse_timer. It is a loadable down-counter with a zero flag, reused for SETUP, HOLD, IOUP and the watchdog.
- The byte engine is instantiated by the parent, not inside this block.

Test Plan:
- Write addr 0x0E, len=8, data 0x3FFF_0000_1234_5678, ioup=1, byte-engine model → bytes 0x0E,3F,FF,00,00,12,34,56,78 in order. CSB low across all nine bytes. IO_UPDATE high 4 cycles after CSB rises. resp_valid with resp_err=0.
- Read addr 0x07, len=4, engine returns 0xA1,0xB2,0xC3,0xD4 on data bytes → first spi_din=0x87, resp_data=0x...A1B2C3D4, IO_UPDATE never asserted.
- len=0 write addr 0x01 → exactly one start pulse, spi_din=0x01, resp_data=0.
- Engine holds spi_done low after start → resp_err=1 after TIMEOUT cycles, CSB returns high, no IO_UPDATE, req_ready returns.
- rst asserted mid-WAIT of byte 3 → next cycle CSB=1, req_ready=1, no resp_valid. A following request runs correctly from byte 0.
- req_len=12 with MAX_BYTES=8 → exactly 9 start pulses. req_valid held during busy → second request accepted only after resp_valid.
